// File: rtl/hdmi_framer_pkg.sv
// Shared types and fixed HDMI period lengths for the data island framer.
package hdmi_framer_pkg;

  // Per-pixel mode handed to the TMDS channel encoders
  typedef enum logic [2:0] {
    MODE_CTRL      = 3'd0,
    MODE_VIDEO     = 3'd1,
    MODE_VIDEO_GB  = 3'd2,
    MODE_ISLAND    = 3'd3,
    MODE_ISLAND_GB = 3'd4
  } mode_e;

  // Island scheduler state; pix_cnt counts pixels within each state
  typedef enum logic [2:0] {
    ST_CTRL,
    ST_DI_PRE,
    ST_DI_LGB,
    ST_DI_DATA,
    ST_DI_TGB
  } state_e;

  localparam int PRE_LEN     = 8;   // data island preamble pixels
  localparam int GB_LEN      = 2;   // island leading/trailing guard band pixels
  localparam int PKT_LEN     = 32;  // pixels per packet
  localparam int VID_PRE_LEN = 8;   // video preamble pixels before active video
  localparam int VID_GB_LEN  = 2;   // video leading guard band pixels

  localparam logic [3:0] VID_PRE_CTL = 4'b0001;
  localparam logic [3:0] DI_PRE_CTL  = 4'b0101;

endpackage

// File: rtl/data_island_framer.sv
// Schedules HDMI data islands inside horizontal blanking and frames every
// pixel period (mode, CTL preamble bits, TERC4 nibbles, delayed syncs).
// Optional build macro FRAMER_DVI_MODE_EN adds a dvi_mode input that keeps
// the link in plain DVI signalling (no islands, no video preamble/guard band).
module data_island_framer
  import hdmi_framer_pkg::*;
#(
  parameter int MAX_PACKETS = 18,
  parameter int CTRL_GAP    = 12,
  parameter int BLANK_W     = 12
) (
  input  logic               clk_pixel,
  input  logic               reset_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               video_active,
  input  logic [BLANK_W-1:0] blank_remaining,
  input  logic               packet_pending,
  input  logic [8:0]         packet_data,
`ifdef FRAMER_DVI_MODE_EN
  input  logic               dvi_mode,
`endif
  output logic               packet_done,
  output logic               data_island_period,
  output logic [2:0]         mode,
  output logic [3:0]         ctl,
  output logic [3:0]         terc4_ch0,
  output logic [3:0]         terc4_ch1,
  output logic [3:0]         terc4_ch2,
  output logic [1:0]         sync_out
);

  localparam int GAP_W = $clog2(CTRL_GAP + 1);
  localparam int PKT_W = $clog2(MAX_PACKETS + 1);
  localparam int REM_W = BLANK_W + 1;

  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(CTRL_GAP);
  localparam logic [PKT_W-1:0] PKT_CAP = PKT_W'(MAX_PACKETS - 1);
  localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);
  localparam logic [4:0] GB_LAST  = 5'(GB_LEN - 1);
  localparam logic [4:0] PKT_LAST = 5'(PKT_LEN - 1);

  // Whole island plus the trailing control gap and the video preamble/guard
  // band must fit in what is left of blanking, counting the current pixel.
  localparam logic [REM_W-1:0] START_BUDGET =
    REM_W'(PRE_LEN + GB_LEN + PKT_LEN + GB_LEN + CTRL_GAP + VID_PRE_LEN + VID_GB_LEN);
  // Another packet after pixel 31: (rem - 1) >= budget, written as rem >= budget + 1
  // so a zero remaining count can never wrap.
  localparam logic [REM_W-1:0] NEXT_BUDGET =
    REM_W'(PKT_LEN + GB_LEN + CTRL_GAP + VID_PRE_LEN + VID_GB_LEN + 1);
  localparam logic [REM_W-1:0] VGB_HI  = REM_W'(VID_GB_LEN);
  localparam logic [REM_W-1:0] VPRE_HI = REM_W'(VID_GB_LEN + VID_PRE_LEN);

  state_e             state_q, state_d, cur_state;
  logic [4:0]         pix_cnt_q, pix_cnt_d, cur_pix;
  logic [PKT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  mode_e              mode_q, mode_d;
  logic [3:0]         ctl_q, ctl_d;
  logic [3:0]         ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d;
  logic [1:0]         sync_q, sync_d;
  logic [REM_W-1:0]   rem_ext;
  logic               abort, start_island, first_px, done_c, dvi_now;

  // dvi_mode only matters while in CTRL, so islands already underway are
  // never affected by a change of it.
`ifdef FRAMER_DVI_MODE_EN
  assign dvi_now = dvi_mode;
`else
  assign dvi_now = 1'b0;
`endif

  // Resolve the state of the current pixel, then its outputs and successor
  always_comb begin
    rem_ext      = {1'b0, blank_remaining};
    abort        = video_active && (state_q != ST_CTRL);
    start_island = (state_q == ST_CTRL) && !video_active && packet_pending && !dvi_now
                   && (gap_cnt_q >= GAP_SAT) && (rem_ext >= START_BUDGET);

    // Video inside an island is a scheduling error: this pixel is already CTRL.
    cur_state = state_q;
    cur_pix   = pix_cnt_q;
    if (video_active) begin
      cur_state = ST_CTRL;
      cur_pix   = '0;
    end else if (start_island) begin
      cur_state = ST_DI_PRE;
      cur_pix   = '0;
    end

    first_px  = (cur_pix == '0) && (pkt_cnt_q == '0);
    state_d   = cur_state;
    pix_cnt_d = cur_pix + 5'd1;
    pkt_cnt_d = pkt_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_c    = 1'b0;
    mode_d    = MODE_CTRL;
    ctl_d     = '0;
    ch0_d     = '0;
    ch1_d     = '0;
    ch2_d     = '0;
    sync_d    = {vsync, hsync};

    case (cur_state)
      ST_CTRL: begin
        pix_cnt_d = '0;
        pkt_cnt_d = '0;
        // An aborted island restarts the minimum control period from zero.
        if (abort)
          gap_cnt_d = '0;
        else if (gap_cnt_q < GAP_SAT)
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (video_active)
          mode_d = MODE_VIDEO;
        else if (!dvi_now && (rem_ext != '0) && (rem_ext <= VGB_HI))
          mode_d = MODE_VIDEO_GB;
        else if (!dvi_now && (rem_ext > VGB_HI) && (rem_ext <= VPRE_HI))
          ctl_d = VID_PRE_CTL;
      end
      ST_DI_PRE: begin
        ctl_d = DI_PRE_CTL;
        if (cur_pix == PRE_LAST) begin
          state_d   = ST_DI_LGB;
          pix_cnt_d = '0;
        end
      end
      ST_DI_LGB: begin
        mode_d = MODE_ISLAND_GB;
        ch0_d  = {2'b11, vsync, hsync};
        if (cur_pix == GB_LAST) begin
          state_d   = ST_DI_DATA;
          pix_cnt_d = '0;
        end
      end
      ST_DI_DATA: begin
        mode_d = MODE_ISLAND;
        ch0_d  = {~first_px, packet_data[0], vsync, hsync};
        ch1_d  = packet_data[4:1];
        ch2_d  = packet_data[8:5];
        if (cur_pix == PKT_LAST) begin
          done_c    = 1'b1;
          pix_cnt_d = '0;
          if (packet_pending && (pkt_cnt_q < PKT_CAP) && (rem_ext >= NEXT_BUDGET))
            pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
          else
            state_d = ST_DI_TGB;
        end
      end
      ST_DI_TGB: begin
        mode_d = MODE_ISLAND_GB;
        ch0_d  = {2'b11, vsync, hsync};
        if (cur_pix == GB_LAST) begin
          state_d   = ST_CTRL;
          pix_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CTRL;
        pix_cnt_d = '0;
      end
    endcase
  end

  // Scheduler state and the one-pixel-delayed output register stage
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CTRL;
      pix_cnt_q <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      mode_q    <= MODE_CTRL;
      ctl_q     <= '0;
      ch0_q     <= '0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      mode_q    <= mode_d;
      ctl_q     <= ctl_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
      sync_q    <= sync_d;
    end
  end

  assign data_island_period = (cur_state == ST_DI_DATA);
  assign packet_done        = done_c;
  assign mode               = mode_q;
  assign ctl                = ctl_q;
  assign terc4_ch0          = ch0_q;
  assign terc4_ch1          = ch1_q;
  assign terc4_ch2          = ch2_q;
  assign sync_out           = sync_q;

endmodule
